vencode_subcarrier_ctrl: RTL and testbench
==========================================

Name: vencode_subcarrier_ctrl

Overview:
Colour-subcarrier sequencer for the composite video encoder. A phase accumulator (NCO) generates the 8-bit phase that drives the sin/cos lookup. A per-line state machine opens the colour-burst window and applies the NTSC or PAL burst phase offset. The block also tracks PAL V-switch alternation. Burst and V-switch strobes are delayed so they line up with the sin/cos lookup output, which has one cycle of latency.

Parameters:
ACC_WIDTH, 32, phase accumulator width; phase output is the top 8 bits.
PHASE_INC, 32'd680080268, per-clock accumulator increment (about 4.4336 MHz at 28 MHz clk).
BURST_DELAY, 8'd40, clocks from line_start to burst window start (range 1..255).
BURST_LEN, 8'd28, burst window length in clocks (0 means no burst).
LAT, 1, delay in cycles applied to burst_q and v_switch_q (range 0..3).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
mode_pal  in  1  1 = PAL (alternating burst, V-switch), 0 = NTSC
line_start  in  1  single-cycle pulse at the start of each line's sync
field_start  in  1  single-cycle pulse at the start of each field
phase_reset  in  1  single-cycle pulse that clears the accumulator
phase  out  8  phase to the sin/cos lookup
burst_q  out  1  burst window, delayed by LAT
v_switch_q  out  1  PAL V-switch, delayed by LAT

Behaviour:
- Reset (async assert, sync release):
  - acc = 0, state = IDLE, cnt = 0, burst_win = 0, v_switch = 0, all delay stages = 0.
  - Outputs therefore reset to phase = 0, burst_q = 0, v_switch_q = 0.
- Accumulator:
  - Every clk, acc <= acc + PHASE_INC, wrapping modulo 2^ACC_WIDTH.
  - If phase_reset = 1 in a cycle, acc <= 0 instead; no increment is applied that cycle.
- phase (combinational from registers):
  - phase = acc[ACC_WIDTH-1 -: 8] + offset, 8-bit wrap.
  - offset = 0 when burst_win = 0.
  - When burst_win = 1: offset = 8'h80 for NTSC; 8'hA0 for PAL with v_switch = 1; 8'h60 for PAL with v_switch = 0.
- Line state machine: IDLE, DELAY, BURST, ACTIVE.
  - line_start in any state: state <= DELAY, cnt <= BURST_DELAY-1, burst_win <= 0. A new line_start always restarts the sequence, including mid-burst.
  - DELAY: when cnt == 0, go to BURST with cnt <= BURST_LEN-1 and burst_win <= 1. If BURST_LEN = 0, go to ACTIVE instead and burst_win stays 0. Otherwise cnt decrements.
  - BURST: when cnt == 0, go to ACTIVE with burst_win <= 0. Otherwise cnt decrements.
  - ACTIVE: hold until the next line_start.
  - IDLE: hold until the first line_start after reset.
  - Net timing: with line_start sampled at edge E0, burst_win is high after edges E(BURST_DELAY) through E(BURST_DELAY+BURST_LEN-1), i.e. BURST_LEN clocks.
- V-switch:
  - PAL: v_switch toggles on each line_start.
  - field_start clears v_switch to 0. If field_start and line_start occur in the same cycle, field_start wins and the result is 0.
  - mode_pal = 0 forces v_switch <= 0 on every clock.
  - Changes to mode_pal take effect in burst offset selection from the next cycle.
- Alignment:
  - burst_q = burst_win delayed by LAT registers; v_switch_q likewise.
  - LAT = 0 passes the signals through combinationally.
- Simultaneous line_start and phase_reset: both take effect (acc cleared, sequence restarted).
- Async reset asserted mid-burst: all outputs go to 0 immediately; no burst until the next line_start after release.

Test Plan:
- Reset: hold rst_n = 0 with random inputs -> phase = 0, burst_q = 0, v_switch_q = 0. Release, no pulses, PHASE_INC = 32'h0100_0000 -> phase reads 1, 2, 3 on successive edges; reads 0 again 256 clocks after release (wrap).
- NTSC burst with BURST_DELAY = 4, BURST_LEN = 3, PHASE_INC = 32'h0100_0000, mode_pal = 0, phase_reset and line_start together at E0 -> acc top byte = 0 after E0.
  - After E4..E6: phase = 8'h84, 8'h85, 8'h86 (acc top 4..6 + 8'h80).
  - After E7: phase = 8'h07, burst back to 0.
  - burst_q high after E5..E7 (LAT = 1).
- PAL alternation, mode_pal = 1 -> first line_start: v_switch_q goes to 1 one cycle later, burst offset 8'hA0. Second line: offset 8'h60, v_switch_q = 0. field_start together with a line_start -> v_switch = 0, offset 8'h60.
- Restart mid-burst: second line_start at E5 of the above NTSC case -> burst_win drops after E5 and rises again after E9; total burst_win high time is E4 plus E9..E11.
- BURST_LEN = 0 -> burst_q never asserts across 3 lines; phase never carries an offset.
- rst_n pulsed low during BURST -> burst_q, v_switch_q and phase go to 0 asynchronously. State stays IDLE with no burst until a line_start after release.

Source files
------------

// File: rtl/vencode_subcarrier_ctrl.sv
// vencode_subcarrier_ctrl
//   Colour-subcarrier sequencer for the composite video encoder.
//   A phase accumulator (NCO) produces the 8-bit phase for the sin/cos
//   lookup. A per-line state machine opens the colour-burst window and adds
//   the NTSC / PAL burst phase offset. PAL V-switch alternation is tracked
//   here. Burst and V-switch strobes are delayed by LAT cycles to line up
//   with the lookup output.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   mode_pal     1 = PAL (alternating burst, V-switch), 0 = NTSC
//   line_start   single-cycle pulse at start of each line's sync
//   field_start  single-cycle pulse at start of each field
//   phase_reset  single-cycle pulse clearing the accumulator
//   phase        [7:0] phase to the sin/cos lookup
//   burst_q      burst window, delayed by LAT
//   v_switch_q   PAL V-switch, delayed by LAT
//
// Handshake: there is no valid/ready flow control; every input is a
// level or single-cycle pulse sampled on each rising clk edge.
module vencode_subcarrier_ctrl #(
    parameter int          ACC_WIDTH   = 32,
    parameter logic [31:0] PHASE_INC   = 32'd680080268,
    parameter logic [7:0]  BURST_DELAY = 8'd40,
    parameter logic [7:0]  BURST_LEN   = 8'd28,
    parameter int          LAT         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_pal,
    input  logic       line_start,
    input  logic       field_start,
    input  logic       phase_reset,
    output logic [7:0] phase,
    output logic       burst_q,
    output logic       v_switch_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        BURST  = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    localparam logic [ACC_WIDTH-1:0] INC = ACC_WIDTH'(PHASE_INC);

    logic [ACC_WIDTH-1:0] acc;
    state_t               state, state_d;
    logic [7:0]           cnt, cnt_d;
    logic                 burst_win, burst_win_d;
    logic                 v_switch;
    logic [7:0]           offset;

    // Phase accumulator; phase_reset overrides the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (phase_reset) begin
            acc <= '0;
        end else begin
            acc <= acc + INC;
        end
    end

    // Burst phase offset: NTSC 180 deg, PAL 180 +/- 45 deg by V-switch.
    always_comb begin
        offset = 8'h00;
        if (burst_win) begin
            if (!mode_pal) begin
                offset = 8'h80;
            end else if (v_switch) begin
                offset = 8'hA0;
            end else begin
                offset = 8'h60;
            end
        end
    end

    assign phase = acc[ACC_WIDTH-1 -: 8] + offset;

    // Line state machine: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            burst_win <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            burst_win <= burst_win_d;
        end
    end

    // Line state machine: next state. A line_start restarts the sequence
    // from any state, including mid-burst.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        burst_win_d = burst_win;
        if (line_start) begin
            state_d     = DELAY;
            cnt_d       = BURST_DELAY - 8'd1;
            burst_win_d = 1'b0;
        end else begin
            case (state)
                DELAY: begin
                    if (cnt == 8'd0) begin
                        if (BURST_LEN == 8'd0) begin
                            state_d = ACTIVE;
                        end else begin
                            state_d     = BURST;
                            cnt_d       = BURST_LEN - 8'd1;
                            burst_win_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                BURST: begin
                    if (cnt == 8'd0) begin
                        state_d     = ACTIVE;
                        burst_win_d = 1'b0;
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                default: begin
                    // IDLE and ACTIVE wait for the next line_start.
                end
            endcase
        end
    end

    // V-switch: field_start beats line_start; NTSC holds it at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_switch <= 1'b0;
        end else if (!mode_pal || field_start) begin
            v_switch <= 1'b0;
        end else if (line_start) begin
            v_switch <= ~v_switch;
        end
    end

    // Alignment delay to match the sin/cos lookup latency.
    generate
        if (LAT == 0) begin : g_no_delay
            assign burst_q    = burst_win;
            assign v_switch_q = v_switch;
        end else begin : g_delay
            logic [LAT-1:0] burst_pipe;
            logic [LAT-1:0] vs_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    burst_pipe <= '0;
                    vs_pipe    <= '0;
                end else begin
                    burst_pipe[0] <= burst_win;
                    vs_pipe[0]    <= v_switch;
                    for (int i = 1; i < LAT; i++) begin
                        burst_pipe[i] <= burst_pipe[i-1];
                        vs_pipe[i]    <= vs_pipe[i-1];
                    end
                end
            end
            assign burst_q    = burst_pipe[LAT-1];
            assign v_switch_q = vs_pipe[LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_vencode_subcarrier_ctrl.sv
// tb_vencode_subcarrier_ctrl
//   Directed bench for vencode_subcarrier_ctrl. Two instances share all
//   inputs: u_dut (BURST_DELAY=4, BURST_LEN=3) and u_dut0 (BURST_LEN=0).
//   PHASE_INC = 32'h0100_0000 so the phase top byte steps by 1 per clock.
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
module tb_vencode_subcarrier_ctrl;

    logic       clk;
    logic       rst_n;
    logic       mode_pal;
    logic       line_start;
    logic       field_start;
    logic       phase_reset;
    logic [7:0] phase;
    logic       burst_q;
    logic       v_switch_q;
    logic [7:0] phase0;
    logic       burst_q0;
    logic       v_switch_q0;

    int n_checks = 0;
    int n_pass   = 0;

    vencode_subcarrier_ctrl #(
        .ACC_WIDTH  (32),
        .PHASE_INC  (32'h0100_0000),
        .BURST_DELAY(8'd4),
        .BURST_LEN  (8'd3),
        .LAT        (1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_pal   (mode_pal),
        .line_start (line_start),
        .field_start(field_start),
        .phase_reset(phase_reset),
        .phase      (phase),
        .burst_q    (burst_q),
        .v_switch_q (v_switch_q)
    );

    vencode_subcarrier_ctrl #(
        .ACC_WIDTH  (32),
        .PHASE_INC  (32'h0100_0000),
        .BURST_DELAY(8'd4),
        .BURST_LEN  (8'd0),
        .LAT        (1)
    ) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_pal   (mode_pal),
        .line_start (line_start),
        .field_start(field_start),
        .phase_reset(phase_reset),
        .phase      (phase0),
        .burst_q    (burst_q0),
        .v_switch_q (v_switch_q0)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One line with line_start+phase_reset at E0, observed after E0..E8.
    // off: expected burst offset; v_exp: V-switch after the line_start;
    // v_prev: V-switch before it (still visible through the delay at E0).
    task automatic run_line(input logic pal, input logic fs, input logic [7:0] off,
                            input logic v_exp, input logic v_prev);
        logic [7:0] e_ph;
        logic [7:0] e_ph0;
        logic       e_bq;
        logic       e_v;
        @(negedge clk);
        mode_pal    = pal;
        line_start  = 1'b1;
        phase_reset = 1'b1;
        field_start = fs;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            e_ph0 = 8'(k);
            e_ph  = 8'(k) + ((k >= 4 && k <= 6) ? off : 8'h00);
            e_bq  = (k >= 5 && k <= 7);
            e_v   = (k == 0) ? v_prev : v_exp;
            n_checks++;
            if (phase !== e_ph) $display("FAIL line_phase E%0d: got %h expected %h", k, phase, e_ph);
            else n_pass++;
            n_checks++;
            if (burst_q !== e_bq) $display("FAIL line_burst_q E%0d: got %b expected %b", k, burst_q, e_bq);
            else n_pass++;
            n_checks++;
            if (v_switch_q !== e_v) $display("FAIL line_v_switch_q E%0d: got %b expected %b", k, v_switch_q, e_v);
            else n_pass++;
            n_checks++;
            if (phase0 !== e_ph0) $display("FAIL nob_phase E%0d: got %h expected %h", k, phase0, e_ph0);
            else n_pass++;
            n_checks++;
            if (burst_q0 !== 1'b0) $display("FAIL nob_burst_q E%0d: got %b expected 0", k, burst_q0);
            else n_pass++;
            n_checks++;
            if (v_switch_q0 !== e_v) $display("FAIL nob_v_switch_q E%0d: got %b expected %b", k, v_switch_q0, e_v);
            else n_pass++;
            if (k == 0) begin
                @(negedge clk);
                line_start  = 1'b0;
                phase_reset = 1'b0;
                field_start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] e_ph;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mode_pal    = 1'($urandom_range(0, 1));
            line_start  = 1'($urandom_range(0, 1));
            field_start = 1'($urandom_range(0, 1));
            phase_reset = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n_checks++;
            if (phase !== 8'h00) $display("FAIL reset_phase: got %h expected 00", phase);
            else n_pass++;
            n_checks++;
            if (burst_q !== 1'b0) $display("FAIL reset_burst_q: got %b expected 0", burst_q);
            else n_pass++;
            n_checks++;
            if (v_switch_q !== 1'b0) $display("FAIL reset_v_switch_q: got %b expected 0", v_switch_q);
            else n_pass++;
        end
        @(negedge clk);
        mode_pal    = 1'b0;
        line_start  = 1'b0;
        field_start = 1'b0;
        phase_reset = 1'b0;
        rst_n       = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            if (i <= 3 || i == 256) begin
                e_ph = 8'(i);
                n_checks++;
                if (phase !== e_ph) $display("FAIL nco_step %0d: got %h expected %h", i, phase, e_ph);
                else n_pass++;
                n_checks++;
                if (burst_q !== 1'b0) $display("FAIL idle_burst_q %0d: got %b expected 0", i, burst_q);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ntsc_burst();
        run_line(1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_pal_alternation();
        run_line(1'b1, 1'b0, 8'hA0, 1'b1, 1'b0);
        run_line(1'b1, 1'b0, 8'h60, 1'b0, 1'b1);
        run_line(1'b1, 1'b0, 8'hA0, 1'b1, 1'b0);
        // field_start with line_start: cleared rather than toggled.
        run_line(1'b1, 1'b1, 8'h60, 1'b0, 1'b1);
    endtask

    task automatic test_restart_mid_burst();
        logic [7:0] e_ph;
        logic       e_bw;
        logic       e_bq;
        @(negedge clk);
        mode_pal    = 1'b0;
        line_start  = 1'b1;
        phase_reset = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(posedge clk);
            #1;
            e_bw = (k == 4) || (k >= 9 && k <= 11);
            e_bq = (k == 5) || (k >= 10 && k <= 12);
            e_ph = 8'(k) + (e_bw ? 8'h80 : 8'h00);
            n_checks++;
            if (phase !== e_ph) $display("FAIL restart_phase E%0d: got %h expected %h", k, phase, e_ph);
            else n_pass++;
            n_checks++;
            if (burst_q !== e_bq) $display("FAIL restart_burst_q E%0d: got %b expected %b", k, burst_q, e_bq);
            else n_pass++;
            @(negedge clk);
            line_start  = (k == 4);   // second line_start sampled at E5
            phase_reset = 1'b0;
        end
    endtask

    task automatic test_no_burst();
        for (int l = 0; l < 3; l++) begin
            run_line(1'b0, 1'b0, 8'h80, 1'b0, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] e_ph;
        @(negedge clk);
        mode_pal    = 1'b1;
        line_start  = 1'b1;
        phase_reset = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                @(negedge clk);
                line_start  = 1'b0;
                phase_reset = 1'b0;
            end
        end
        n_checks++;
        if (phase !== 8'hA5) $display("FAIL pre_rst_phase: got %h expected a5", phase);
        else n_pass++;
        n_checks++;
        if (burst_q !== 1'b1) $display("FAIL pre_rst_burst_q: got %b expected 1", burst_q);
        else n_pass++;
        n_checks++;
        if (v_switch_q !== 1'b1) $display("FAIL pre_rst_v_switch_q: got %b expected 1", v_switch_q);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (phase !== 8'h00) $display("FAIL async_rst_phase: got %h expected 00", phase);
        else n_pass++;
        n_checks++;
        if (burst_q !== 1'b0) $display("FAIL async_rst_burst_q: got %b expected 0", burst_q);
        else n_pass++;
        n_checks++;
        if (v_switch_q !== 1'b0) $display("FAIL async_rst_v_switch_q: got %b expected 0", v_switch_q);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            e_ph = 8'(i);
            n_checks++;
            if (phase !== e_ph) $display("FAIL post_rst_phase %0d: got %h expected %h", i, phase, e_ph);
            else n_pass++;
            n_checks++;
            if (burst_q !== 1'b0) $display("FAIL post_rst_burst_q %0d: got %b expected 0", i, burst_q);
            else n_pass++;
            n_checks++;
            if (v_switch_q !== 1'b0) $display("FAIL post_rst_v_switch_q %0d: got %b expected 0", i, v_switch_q);
            else n_pass++;
        end
        // Burst comes back with the next line.
        run_line(1'b1, 1'b0, 8'hA0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        mode_pal    = 1'b0;
        line_start  = 1'b0;
        field_start = 1'b0;
        phase_reset = 1'b0;
        test_reset();
        test_ntsc_burst();
        test_pal_alternation();
        test_restart_mid_burst();
        test_no_burst();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
